// File: rtl/robot_motion_ctrl_if.sv
// robot_motion_ctrl_if: UART-side command strobe in, event byte out with valid/ready.
interface robot_motion_ctrl_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic [7:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;
    modport master (output cmd_data, cmd_valid, evt_ready, input evt_data, evt_valid);
    modport slave (input cmd_data, cmd_valid, evt_ready, output evt_data, evt_valid);
endinterface

// File: rtl/robot_motion_ctrl.sv
// robot_motion_ctrl: line-following two-wheel servo controller with UART commands and events.
module robot_motion_ctrl #(
    parameter int PWM_PERIOD   = 2000000,
    parameter int PULSE_MID    = 150000,
    parameter int PULSE_DELTA  = 50000,
    parameter int CROSS_FRAMES = 3,
    parameter int TURN_MIN     = 10,
    parameter int TURN_MAX     = 100,
    parameter int LOST_MAX     = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          sensor,
    robot_motion_ctrl_if.slave  bus,
    output logic [1:0]          servo,
    output logic [2:0]          state
);
    localparam int CW = $clog2(PWM_PERIOD);
    localparam logic [CW-1:0] W_STOP = CW'(PULSE_MID);
    localparam logic [CW-1:0] W_HI = CW'(PULSE_MID + PULSE_DELTA);
    localparam logic [CW-1:0] W_LO = CW'(PULSE_MID - PULSE_DELTA);
    localparam logic [CW-1:0] LAST = CW'(PWM_PERIOD - 1);
    localparam logic [15:0] C_MAX = 16'(CROSS_FRAMES);
    localparam logic [15:0] T_MIN = 16'(TURN_MIN);
    localparam logic [15:0] T_MAX = 16'(TURN_MAX);
    localparam logic [15:0] L_MAX = 16'(LOST_MAX);

    typedef enum logic [2:0] {IDLE = 3'd0, FOLLOW = 3'd1, CROSS = 3'd2, TURN_L = 3'd3, TURN_R = 3'd4} st_t;

    st_t           st, st_n;
    logic [2:0]    s1, s2;
    logic [CW-1:0] cnt, wl, wr, wl_n, wr_n;
    logic [15:0]   cross_cnt, lost_cnt, turn_cnt, cross_n, lost_n, turn_n;
    logic          fs, hit, ev;
    logic [7:0]    ev_byte;

    assign state = st;

    always_comb begin
        fs = cnt == '0;
        st_n = st;
        cross_n = cross_cnt;
        lost_n = lost_cnt;
        turn_n = turn_cnt;
        hit = 1'b0;
        ev = 1'b0;
        ev_byte = 8'h00;
        // right wheel is mirrored: its forward pulse is the short one
        wl_n = W_STOP;
        wr_n = W_STOP;
        if (st == TURN_L) begin
            wl_n = W_LO;
            wr_n = W_LO;
        end else if (st == TURN_R) begin
            wl_n = W_HI;
            wr_n = W_HI;
        end else if (st == FOLLOW) begin
            wl_n = (s2 == 3'b000) ? wl : (s2 == 3'b100 || s2 == 3'b110) ? W_STOP : W_HI;
            wr_n = (s2 == 3'b000) ? wr : (s2 == 3'b001 || s2 == 3'b011) ? W_STOP : W_LO;
        end
        if (bus.cmd_valid) begin
            if (bus.cmd_data == 8'h53) begin
                hit = 1'b1;
                st_n = IDLE;
                ev = 1'b1;
                ev_byte = 8'h53;
            end else if (bus.cmd_data == 8'h46 && (st == IDLE || st == CROSS)) begin
                hit = 1'b1;
                st_n = FOLLOW;
            end else if (st == CROSS && (bus.cmd_data == 8'h4C || bus.cmd_data == 8'h52)) begin
                hit = 1'b1;
                st_n = (bus.cmd_data == 8'h4C) ? TURN_L : TURN_R;
            end
        end
        // an accepted command pre-empts the frame decision of the same cycle
        if (fs && !hit && st == FOLLOW) begin
            if (s2 == 3'b111) begin
                cross_n = cross_cnt + 16'd1;
                lost_n = '0;
                if (cross_n >= C_MAX) begin
                    st_n = CROSS;
                    ev = 1'b1;
                    ev_byte = 8'h43;
                end
            end else begin
                cross_n = '0;
                lost_n = (s2 == 3'b000) ? lost_cnt + 16'd1 : '0;
                if (lost_n >= L_MAX) begin
                    st_n = IDLE;
                    ev = 1'b1;
                    ev_byte = 8'h58;
                end
            end
        end else if (fs && !hit && (st == TURN_L || st == TURN_R)) begin
            turn_n = turn_cnt + 16'd1;
            if (turn_n >= T_MIN && s2[1]) begin
                st_n = FOLLOW;
                ev = 1'b1;
                ev_byte = 8'h54;
            end else if (turn_n >= T_MAX) begin
                st_n = IDLE;
                ev = 1'b1;
                ev_byte = 8'h45;
            end
        end
        if (st_n != st) begin
            cross_n = '0;
            lost_n = '0;
            turn_n = '0;
        end
    end

    // servo is registered, so the pulse trails the counter by one cycle
    // and the width loaded at frame start governs the whole frame
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            cnt <= '0;
            wl <= W_STOP;
            wr <= W_STOP;
            servo <= 2'b00;
            st <= IDLE;
            cross_cnt <= '0;
            lost_cnt <= '0;
            turn_cnt <= '0;
            bus.evt_valid <= 1'b0;
            bus.evt_data <= 8'h00;
        end else begin
            s1 <= sensor;
            s2 <= s1;
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (fs) begin
                wl <= wl_n;
                wr <= wr_n;
            end
            servo <= {cnt < wl, cnt < wr};
            st <= st_n;
            cross_cnt <= cross_n;
            lost_cnt <= lost_n;
            turn_cnt <= turn_n;
            bus.evt_valid <= ev | (bus.evt_valid & ~bus.evt_ready);
            if (ev) bus.evt_data <= ev_byte;
        end
    end
endmodule

// File: tb/tb_robot_motion_ctrl.sv
// tb_robot_motion_ctrl: directed frame-by-frame checks of steering, events and reset.
module tb_robot_motion_ctrl;
    localparam int PERIOD = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sensor = 3'b000;
    logic [1:0] servo;
    logic [2:0] state;
    logic [2:0] st_cmd;
    int         checks = 0;
    int         errors = 0;
    int         l, r;

    robot_motion_ctrl_if bus();

    robot_motion_ctrl #(
        .PWM_PERIOD(PERIOD), .PULSE_MID(75), .PULSE_DELTA(25), .CROSS_FRAMES(3),
        .TURN_MIN(2), .TURN_MAX(6), .LOST_MAX(4)
    ) dut (
        .clk(clk), .reset(reset), .sensor(sensor), .bus(bus), .servo(servo), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        bus.cmd_data = c;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic accept();
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
    endtask

    // waits for the next pulse rise and counts high cycles over one frame;
    // optionally strobes a command at sample cmd_at and records state one cycle later
    task automatic frame(input int cmd_at, input logic [7:0] c, output int lw, output int rw);
        logic p;
        bit   found;
        lw = 0;
        rw = 0;
        p = servo[1];
        found = 1'b0;
        for (int i = 0; i < PERIOD + 100 && !found; i++) begin
            @(negedge clk);
            found = servo[1] && !p;
            p = servo[1];
        end
        chk("frame_start", 32'(found), 32'd1);
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            if (i == cmd_at) begin
                bus.cmd_data = c;
                bus.cmd_valid = 1'b1;
            end
            if (i == cmd_at + 1) begin
                bus.cmd_valid = 1'b0;
                st_cmd = state;
            end
            lw += int'(servo[1]);
            rw += int'(servo[0]);
        end
    endtask

    initial begin
        bus.cmd_data = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.evt_ready = 1'b0;
        step(3);
        chk("rst_servo", 32'(servo), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        chk("rst_evt_data", 32'(bus.evt_data), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            frame(-5, 8'h00, l, r);
            chk("idle_left", 32'(l), 32'd75);
            chk("idle_right", 32'(r), 32'd75);
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_evt", 32'(bus.evt_valid), 32'd0);
        end
        step(5);
        send(8'h5A);
        chk("bad_cmd_state", 32'(state), 32'd0);
        send(8'h4C);
        chk("idle_L_ignored", 32'(state), 32'd0);
        chk("ignored_no_evt", 32'(bus.evt_valid), 32'd0);
        sensor = 3'b010;
        send(8'h46);
        chk("F_state", 32'(state), 32'd1);
        frame(-5, 8'h00, l, r);
        chk("fwd_left", 32'(l), 32'd100);
        chk("fwd_right", 32'(r), 32'd50);
        sensor = 3'b100;
        frame(-5, 8'h00, l, r);
        chk("sync_lag_left", 32'(l), 32'd100);
        frame(-5, 8'h00, l, r);
        chk("steer_left", 32'(l), 32'd75);
        chk("steer_right", 32'(r), 32'd50);
        sensor = 3'b111;
        frame(-5, 8'h00, l, r);
        frame(-5, 8'h00, l, r);
        chk("cand_left", 32'(l), 32'd100);
        chk("cand_right", 32'(r), 32'd50);
        frame(-5, 8'h00, l, r);
        chk("cross_pre_state", 32'(state), 32'd1);
        chk("cross_pre_evt", 32'(bus.evt_valid), 32'd0);
        step(1);
        chk("cross_state", 32'(state), 32'd2);
        chk("cross_evt_valid", 32'(bus.evt_valid), 32'd1);
        chk("cross_evt_data", 32'(bus.evt_data), 32'h43);
        step(20);
        chk("cross_evt_held", 32'(bus.evt_valid), 32'd1);
        chk("cross_evt_held_data", 32'(bus.evt_data), 32'h43);
        accept();
        chk("cross_evt_accepted", 32'(bus.evt_valid), 32'd0);
        sensor = 3'b010;
        send(8'h4C);
        chk("turnL_state", 32'(state), 32'd3);
        frame(-5, 8'h00, l, r);
        chk("turnL_left", 32'(l), 32'd50);
        chk("turnL_right", 32'(r), 32'd50);
        chk("turn_min_hold", 32'(state), 32'd3);
        step(1);
        chk("turn_exit_state", 32'(state), 32'd1);
        chk("turn_exit_evt", 32'(bus.evt_data), 32'h54);
        accept();
        sensor = 3'b111;
        frame(-5, 8'h00, l, r);
        frame(-5, 8'h00, l, r);
        step(1);
        chk("cross2_state", 32'(state), 32'd2);
        accept();
        sensor = 3'b000;
        send(8'h4C);
        chk("turnL2_state", 32'(state), 32'd3);
        frame(-5, 8'h00, l, r);
        chk("turnL2_left", 32'(l), 32'd50);
        for (int k = 0; k < 4; k++) frame(-5, 8'h00, l, r);
        chk("turn_max_pre", 32'(state), 32'd3);
        step(1);
        chk("turn_max_state", 32'(state), 32'd0);
        chk("turn_max_evt", 32'(bus.evt_data), 32'h45);
        accept();
        send(8'h46);
        chk("F2_state", 32'(state), 32'd1);
        for (int k = 0; k < 3; k++) frame(-5, 8'h00, l, r);
        chk("lost_pre_state", 32'(state), 32'd1);
        step(1);
        chk("lost_state", 32'(state), 32'd0);
        chk("lost_evt", 32'(bus.evt_data), 32'h58);
        sensor = 3'b111;
        step(2);
        send(8'h46);
        chk("F3_state", 32'(state), 32'd1);
        frame(-5, 8'h00, l, r);
        frame(-5, 8'h00, l, r);
        step(1);
        chk("cross3_state", 32'(state), 32'd2);
        chk("overwrite_valid", 32'(bus.evt_valid), 32'd1);
        chk("overwrite_data", 32'(bus.evt_data), 32'h43);
        sensor = 3'b000;
        send(8'h52);
        chk("turnR_state", 32'(state), 32'd4);
        frame(10, 8'h53, l, r);
        chk("stop_next_cycle", 32'(st_cmd), 32'd0);
        chk("stop_pulse_left", 32'(l), 32'd100);
        chk("stop_pulse_right", 32'(r), 32'd100);
        chk("stop_evt_data", 32'(bus.evt_data), 32'h53);
        chk("stop_evt_valid", 32'(bus.evt_valid), 32'd1);
        frame(-5, 8'h00, l, r);
        chk("stopped_left", 32'(l), 32'd75);
        chk("stopped_right", 32'(r), 32'd75);
        sensor = 3'b111;
        step(3);
        send(8'h46);
        frame(-5, 8'h00, l, r);
        frame(-5, 8'h00, l, r);
        step(1);
        chk("cross4_state", 32'(state), 32'd2);
        send(8'h4C);
        chk("turnL3_state", 32'(state), 32'd3);
        step(8);
        chk("pre_reset_servo", 32'(servo), 32'd3);
        reset = 1'b1;
        step(1);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_servo", 32'(servo), 32'd0);
        chk("mid_rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        chk("mid_rst_evt_data", 32'(bus.evt_data), 32'd0);
        reset = 1'b0;
        frame(-5, 8'h00, l, r);
        chk("post_rst_left", 32'(l), 32'd75);
        chk("post_rst_right", 32'(r), 32'd75);
        chk("post_rst_state", 32'(state), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
